// File: rtl/dna_pkg.sv
// Shared definitions for the read-alignment pipeline: base encodings,
// read geometry and the candidate verifier FSM states.
package dna_pkg;

    localparam int unsigned BASE_W     = 2;
    localparam int unsigned DNA_READ_W = 16;
    localparam int unsigned READ_BASES = DNA_READ_W / BASE_W;

    localparam logic [BASE_W-1:0] BASE_A = 2'b00;
    localparam logic [BASE_W-1:0] BASE_G = 2'b01;
    localparam logic [BASE_W-1:0] BASE_C = 2'b10;
    localparam logic [BASE_W-1:0] BASE_T = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        CMP,
        REPORT,
        FINISH
    } state_t;

endpackage

// File: rtl/cand_fifo.sv
// Synchronous candidate FIFO with combinational read-ahead output.
// A push alongside a pop is accepted even when full.
module cand_fifo #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit: equal low bits with differing MSB means full.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/candidate_verifier.sv
// Buffers seed-lookup candidates and verifies each window base-serially
// against the short read, tracking the best passing alignment.
module candidate_verifier
    import dna_pkg::*;
#(
    parameter int unsigned READ_W     = 16,
    parameter int unsigned IDX_W      = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MAX_MM     = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [READ_W-1:0] shortread,
    input  logic              start,
    input  logic [IDX_W-1:0]  index,
    // "sequence" is a reserved word in SystemVerilog, hence ref_sequence.
    input  logic [READ_W-1:0] ref_sequence,
    input  logic              index_done,
    output logic              hit_valid,
    output logic [IDX_W-1:0]  hit_index,
    output logic [3:0]        hit_mm,
    output logic              hit_pass,
    output logic              busy,
    output logic              overflow,
    output logic              align_done,
    output logic              best_valid,
    output logic [IDX_W-1:0]  best_index,
    output logic [3:0]        best_mm
);

    localparam int unsigned NB = READ_W / BASE_W;
    localparam int unsigned CW = $clog2(NB);
    localparam logic [CW-1:0] LAST_BASE = CW'(NB - 1);
    localparam logic [3:0]    MAX_MM_W  = 4'(MAX_MM);

    state_t            state;
    logic [READ_W-1:0] win_r;
    logic [READ_W-1:0] read_r;
    logic [IDX_W-1:0]  idx_r;
    logic [3:0]        mm_cnt;
    logic [CW-1:0]     base_cnt;
    logic [3:0]        best_score;
    logic [IDX_W-1:0]  last_idx;
    logic              last_idx_valid;

    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    fifo_pop;
    logic [IDX_W+READ_W-1:0] fifo_rdata;
    logic                    is_dup;
    logic                    cand_ok;
    logic                    push_ok;
    logic                    drop_full;
    logic                    base_diff;

    always_comb begin
        fifo_pop  = (state == IDLE) && !fifo_empty;
        is_dup    = last_idx_valid && (index == last_idx);
        cand_ok   = start && !is_dup && (state != FINISH);
        push_ok   = cand_ok && (!fifo_full || fifo_pop);
        drop_full = cand_ok && fifo_full && !fifo_pop;
        base_diff = (win_r[BASE_W*base_cnt +: BASE_W] != read_r[BASE_W*base_cnt +: BASE_W]);
    end

    assign busy = (state != IDLE) || !fifo_empty;

    cand_fifo #(
        .WIDTH (IDX_W + READ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_ok),
        .pop   (fifo_pop),
        .wdata ({index, ref_sequence}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_idx       <= '0;
            last_idx_valid <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            if (push_ok) begin
                last_idx       <= index;
                last_idx_valid <= 1'b1;
            end
            if (drop_full) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            win_r      <= '0;
            read_r     <= '0;
            idx_r      <= '0;
            mm_cnt     <= '0;
            base_cnt   <= '0;
            best_score <= 4'd15;
            hit_valid  <= 1'b0;
            hit_index  <= '0;
            hit_mm     <= '0;
            hit_pass   <= 1'b0;
            align_done <= 1'b0;
            best_valid <= 1'b0;
            best_index <= '0;
            best_mm    <= '0;
        end else begin
            hit_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        idx_r    <= fifo_rdata[READ_W +: IDX_W];
                        win_r    <= fifo_rdata[READ_W-1:0];
                        read_r   <= shortread;
                        mm_cnt   <= '0;
                        base_cnt <= '0;
                        state    <= CMP;
                    // A candidate landing this very cycle must still be verified.
                    end else if (index_done && !push_ok) begin
                        state <= FINISH;
                    end
                end
                CMP: begin
                    if (base_diff) mm_cnt <= mm_cnt + 4'd1;
                    if (base_cnt == LAST_BASE) state <= REPORT;
                    else base_cnt <= base_cnt + 1'b1;
                end
                REPORT: begin
                    hit_valid <= 1'b1;
                    hit_index <= idx_r;
                    hit_mm    <= mm_cnt;
                    hit_pass  <= (mm_cnt <= MAX_MM_W);
                    // Strict less-than keeps the earlier candidate on ties.
                    if ((mm_cnt <= MAX_MM_W) && (mm_cnt < best_score)) begin
                        best_score <= mm_cnt;
                        best_mm    <= mm_cnt;
                        best_index <= idx_r;
                        best_valid <= 1'b1;
                    end
                    state <= IDLE;
                end
                FINISH: begin
                    align_done <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_candidate_verifier.sv
// Directed bench for candidate_verifier: a vector table of single-candidate
// verifications plus hand-written multi-cycle sequences.
module tb_candidate_verifier;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] shortread = '0;
    logic        start = 1'b0;
    logic [7:0]  index = '0;
    logic [15:0] ref_sequence = '0;
    logic        index_done = 1'b0;
    logic        hit_valid;
    logic [7:0]  hit_index;
    logic [3:0]  hit_mm;
    logic        hit_pass;
    logic        busy;
    logic        overflow;
    logic        align_done;
    logic        best_valid;
    logic [7:0]  best_index;
    logic [3:0]  best_mm;

    candidate_verifier #(
        .READ_W     (16),
        .IDX_W      (8),
        .FIFO_DEPTH (4),
        .MAX_MM     (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .shortread    (shortread),
        .start        (start),
        .index        (index),
        .ref_sequence (ref_sequence),
        .index_done   (index_done),
        .hit_valid    (hit_valid),
        .hit_index    (hit_index),
        .hit_mm       (hit_mm),
        .hit_pass     (hit_pass),
        .busy         (busy),
        .overflow     (overflow),
        .align_done   (align_done),
        .best_valid   (best_valid),
        .best_index   (best_index),
        .best_mm      (best_mm)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] rd;
        logic [15:0] sq;
        logic [7:0]  idx;
        logic [3:0]  mm;
        logic        pass;
    } vec_t;

    typedef struct {
        logic [7:0] idx;
        logic [3:0] mm;
        logic       pass;
        int         cyc;
    } hit_t;

    vec_t vecs[10];
    hit_t hit_q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   pc;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (hit_valid) hit_q.push_back('{hit_index, hit_mm, hit_pass, cyc});
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [15:0] rd);
        reset        = 1'b1;
        start        = 1'b0;
        index_done   = 1'b0;
        index        = '0;
        ref_sequence = '0;
        shortread    = rd;
        repeat (2) tick();
        reset = 1'b0;
        hit_q.delete();
    endtask

    task automatic push1(input logic [7:0] idx, input logic [15:0] sq, output int push_cyc);
        index        = idx;
        ref_sequence = sq;
        start        = 1'b1;
        tick();
        start    = 1'b0;
        push_cyc = cyc;
    endtask

    task automatic wait_hits(input int n, input int budget);
        for (int i = 0; i < budget && hit_q.size() < n; i++) tick();
    endtask

    task automatic finish_and_wait(input string nm);
        index_done = 1'b1;
        for (int i = 0; i < 60 && !align_done; i++) tick();
        chk({nm, "_align_done"}, align_done, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{16'hA5C3, 16'hA5C3, 8'd10,  4'd0, 1'b1};
        vecs[1] = '{16'hA5C3, 16'hA5C0, 8'd4,   4'd1, 1'b1};
        vecs[2] = '{16'hA5C3, 16'h5A3C, 8'd20,  4'd8, 1'b0};
        vecs[3] = '{16'h0000, 16'hFFFF, 8'd0,   4'd8, 1'b0};
        vecs[4] = '{16'h0000, 16'h0003, 8'd255, 4'd1, 1'b1};
        vecs[5] = '{16'h0000, 16'h000F, 8'd1,   4'd2, 1'b0};
        vecs[6] = '{16'hFFFF, 16'h7FFF, 8'd2,   4'd1, 1'b1};
        vecs[7] = '{16'h1234, 16'h92B4, 8'd3,   4'd2, 1'b0};
        vecs[8] = '{16'h1B1B, 16'hE4E4, 8'd5,   4'd8, 1'b0};
        vecs[9] = '{16'hC3C3, 16'hC3C2, 8'd6,   4'd1, 1'b1};

        repeat (2) tick();
        chk("reset_outputs", {hit_valid, hit_index, hit_mm, hit_pass, busy, overflow,
                              align_done, best_valid, best_index, best_mm}, 0);

        foreach (vecs[k]) begin
            do_reset(vecs[k].rd);
            push1(vecs[k].idx, vecs[k].sq, pc);
            wait_hits(1, 20);
            chk($sformatf("v%0d_count", k), hit_q.size(), 1);
            if (hit_q.size() > 0) begin
                chk($sformatf("v%0d_latency", k), hit_q[0].cyc - pc, 10);
                chk($sformatf("v%0d_index", k), hit_q[0].idx, vecs[k].idx);
                chk($sformatf("v%0d_mm", k), hit_q[0].mm, vecs[k].mm);
                chk($sformatf("v%0d_pass", k), hit_q[0].pass, vecs[k].pass);
            end
            finish_and_wait($sformatf("v%0d", k));
            chk($sformatf("v%0d_hold_mm", k), hit_mm, vecs[k].mm);
            chk($sformatf("v%0d_best_valid", k), best_valid, vecs[k].pass);
            chk($sformatf("v%0d_best_mm", k), best_mm, vecs[k].pass ? vecs[k].mm : 4'd0);
            chk($sformatf("v%0d_best_index", k), best_index, vecs[k].pass ? vecs[k].idx : 8'd0);
        end

        // Mismatch grading, back-to-back candidates
        do_reset(16'hA5C3);
        push1(8'd4, 16'hA5C0, pc);
        push1(8'd20, 16'h5A3C, pc);
        wait_hits(2, 40);
        chk("grade_count", hit_q.size(), 2);
        if (hit_q.size() >= 2) begin
            chk("grade_idx0", hit_q[0].idx, 4);
            chk("grade_mm0", hit_q[0].mm, 1);
            chk("grade_pass0", hit_q[0].pass, 1);
            chk("grade_idx1", hit_q[1].idx, 20);
            chk("grade_mm1", hit_q[1].mm, 8);
            chk("grade_pass1", hit_q[1].pass, 0);
            chk("grade_spacing", hit_q[1].cyc - hit_q[0].cyc, 10);
        end
        finish_and_wait("grade");
        chk("grade_best_index", best_index, 4);
        chk("grade_best_mm", best_mm, 1);

        // Duplicate drop: same index held for three cycles
        do_reset(16'h0000);
        index        = 8'd7;
        ref_sequence = 16'h0000;
        start        = 1'b1;
        repeat (3) tick();
        start = 1'b0;
        repeat (40) tick();
        chk("dup_count", hit_q.size(), 1);
        chk("dup_overflow", overflow, 0);

        // Overflow: six distinct indices on consecutive cycles
        do_reset(16'h0000);
        for (int i = 0; i < 6; i++) begin
            index        = 8'(60 + i);
            ref_sequence = 16'h0000;
            start        = 1'b1;
            tick();
        end
        start = 1'b0;
        chk("ovf_flag", overflow, 1);
        wait_hits(5, 80);
        repeat (20) tick();
        chk("ovf_count", hit_q.size(), 5);
        for (int i = 0; i < hit_q.size() && i < 5; i++)
            chk($sformatf("ovf_idx%0d", i), hit_q[i].idx, 60 + i);
        finish_and_wait("ovf");

        // Tie keeps the earlier candidate
        do_reset(16'h0000);
        push1(8'd30, 16'h0001, pc);
        push1(8'd31, 16'h0100, pc);
        wait_hits(2, 40);
        chk("tie_count", hit_q.size(), 2);
        finish_and_wait("tie");
        chk("tie_best_index", best_index, 30);
        chk("tie_best_mm", best_mm, 1);

        // No passing candidate
        do_reset(16'h0000);
        push1(8'd40, 16'h000F, pc);
        push1(8'd41, 16'hFFFF, pc);
        wait_hits(2, 40);
        finish_and_wait("nopass");
        chk("nopass_best_valid", best_valid, 0);
        chk("nopass_best_mm", best_mm, 0);

        // Reset asserted in the fourth CMP cycle
        do_reset(16'h0000);
        push1(8'd50, 16'h0000, pc);
        repeat (4) tick();
        reset = 1'b1;
        #1;
        chk("midrst_outputs", {hit_valid, hit_index, hit_mm, hit_pass, busy, overflow,
                               align_done, best_valid, best_index, best_mm}, 0);
        tick();
        reset = 1'b0;
        chk("midrst_no_old_hit", hit_q.size(), 0);
        push1(8'd51, 16'h0003, pc);
        wait_hits(1, 30);
        repeat (20) tick();
        chk("midrst_count", hit_q.size(), 1);
        if (hit_q.size() > 0) begin
            chk("midrst_index", hit_q[0].idx, 51);
            chk("midrst_latency", hit_q[0].cyc - pc, 10);
            chk("midrst_mm", hit_q[0].mm, 1);
        end

        // Late candidate arriving with index_done
        do_reset(16'h0000);
        index        = 8'd70;
        ref_sequence = 16'h0000;
        start        = 1'b1;
        index_done   = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 40 && !align_done; i++) tick();
        chk("late_align_done", align_done, 1);
        chk("late_count", hit_q.size(), 1);
        chk("late_best_index", best_index, 70);
        chk("late_busy_finish", busy, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/candidate_verifier.md
Name: candidate_verifier

Overview:
- Consumer of the seed-lookup stream (start / index / sequence / index_done).
- Buffers candidate reference windows and verifies each one base-serially against the short read.
- Per candidate, reports the mismatch count and whether it passes threshold. At end of search, reports the best-scoring alignment.
- Sits between the seed-lookup stage and the downstream result/display logic.

Parameters:
- READ_W, 16: short-read and window width in bits (2 bits per base; 8 bases).
- IDX_W, 8: candidate index width.
- FIFO_DEPTH, 4: candidate buffer entries; power of two.
- MAX_MM, 1: maximum mismatched bases for a passing hit.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- shortread  in  READ_W  short read; held stable from reset release until align_done
- start  in  1  per-cycle qualifier: index/sequence hold a valid candidate this cycle
- index  in  IDX_W  candidate reference offset
- sequence  in  READ_W  reference window at index
- index_done  in  1  level: seed lookup finished, no further candidates
- hit_valid  out  1  one-cycle pulse: a candidate finished verifying
- hit_index  out  IDX_W  index of the verified candidate
- hit_mm  out  4  mismatched bases (0..8) of the verified candidate
- hit_pass  out  1  hit_mm <= MAX_MM, qualified by hit_valid
- busy  out  1  FSM not IDLE, or FIFO not empty
- overflow  out  1  sticky: a candidate was dropped because the FIFO was full
- align_done  out  1  sticky: all candidates verified
- best_valid  out  1  at least one passing hit seen
- best_index  out  IDX_W  index of the best passing hit
- best_mm  out  4  mismatch count of the best passing hit

Behaviour:
- Reset: all outputs 0; FIFO empty; FSM in IDLE; last_idx_valid = 0; best_mm internal initialiser = 15.
- Push:
  - A candidate is pushed on any clk edge with start = 1, unless one of the drop rules applies.
  - Drop (no push, no flag) if last_idx_valid and index == last_idx. This removes the repeated reports of the same offset that come from successive seeds.
  - Drop if the FIFO is full; set overflow.
  - Every accepted push updates last_idx and sets last_idx_valid.
- Push and pop may occur in the same cycle, including when the FIFO is full. A pop frees a slot in the same cycle, so a push with a simultaneous pop is accepted.
- Pointers are log2(FIFO_DEPTH)+1 bits. Full/empty are detected from the MSB difference; pointers wrap naturally.
- FSM:
  - IDLE: if FIFO not empty, pop into win_r / idx_r, latch shortread into read_r, clear mm_cnt and base_cnt, go to CMP. Else, if index_done = 1, go to FINISH.
  - CMP: one base per cycle, LSB-first. Compare win_r[2b +: 2] with read_r[2b +: 2] and increment mm_cnt on inequality. After 8 cycles (base_cnt == 7), go to REPORT.
  - REPORT (1 cycle):
    - Assert hit_valid with hit_index = idx_r, hit_mm = mm_cnt, hit_pass.
    - If hit_pass and mm_cnt < best_mm: update best_* and set best_valid.
    - Ties keep the earlier candidate.
    - Return to IDLE.
  - FINISH: set align_done; stay here until reset. Candidates arriving in FINISH are ignored.
- Latency: pop to hit_valid is exactly 10 cycles (IDLE pop, 8 CMP cycles, REPORT). Back-to-back candidates give 1 result per 10 cycles.
- hit_index, hit_mm and hit_pass hold their last values between pulses.
- index_done is checked only in IDLE with an empty FIFO. A late candidate (start = 1 in the same cycle index_done is first seen) is pushed and verified before FINISH.
- Reset mid-operation: the in-flight verification is abandoned, the FIFO is flushed, and all outputs return to their reset values.
- mm_cnt is 4 bits and saturates at 8 by construction; no overflow is possible.

Decomposition:
- Shared package dna_pkg holds:
  - base encodings: A = 2'b00, G = 2'b01, C = 2'b10, T = 2'b11;
  - BASE_W = 2;
  - READ_BASES = READ_W / BASE_W;
  - FSM state enum (IDLE, CMP, REPORT, FINISH).
- One sub-module: cand_fifo, a parameterised synchronous FIFO with push, pop, full, empty and a data width of IDX_W + READ_W.
- The duplicate-drop and overflow logic lives in the top level.

Test Plan:
- Exact match:
  - Stimulus: shortread = 16'hA5C3; one candidate, index = 8'd10, sequence = 16'hA5C3; then index_done.
  - Response: hit_valid 10 cycles after pop; hit_mm = 0, hit_pass = 1; best_index = 10, best_mm = 0; align_done.
- Mismatch grading:
  - Stimulus: candidates index 4 with sequence = 16'hA5C0 (1 mismatched base), then index 20 with 16'h5A3C (all 8 bases differ).
  - Response: hit_mm = 1, hit_pass = 1 for index 4; hit_mm = 8, hit_pass = 0 for index 20; best_index = 4.
- Duplicate drop:
  - Stimulus: start held high for 3 cycles with index = 8'd7.
  - Response: exactly 1 hit_valid pulse; overflow = 0.
- Overflow:
  - Stimulus: 6 distinct indices on consecutive cycles.
  - Response: FIFO_DEPTH + 1 = 5 verified (the first candidate pops immediately); overflow = 1; the 6th index is never reported.
- Tie and empty result:
  - Stimulus: two candidates, both with hit_mm = 1.
  - Response: best_index is the first one.
  - Stimulus: separate run where all candidates have hit_mm >= 2.
  - Response: best_valid = 0, align_done = 1.
- Reset mid-CMP:
  - Stimulus: assert reset on the 4th CMP cycle; release and send 1 new candidate.
  - Response: all outputs 0 during reset; the old candidate is never reported; the new candidate is reported 10 cycles after its pop.
